// File: rtl/tdnn_bank_buf_if.sv
// rtl/tdnn_bank_buf_if.sv - host and engine port bundle for tdnn_bank_buf
interface tdnn_bank_buf_if #(
  parameter int DW = 32,
  parameter int AW = 12,
  parameter int NB = 2
);
  localparam int BW = $clog2(NB);
  localparam int FW = AW + BW;

  // host port: one write or read per cycle, held until granted
  logic          h_wr;
  logic          h_rd;
  logic [FW-1:0] h_a;
  logic [DW-1:0] h_wd;
  logic          h_gnt;
  logic          h_rv;
  logic [DW-1:0] h_rdata;

  // engine read port, held until granted
  logic          e_rd;
  logic [FW-1:0] e_ra;
  logic          e_gnt;
  logic          e_rv;
  logic [DW-1:0] e_rdata;

  // engine write port, never stalled
  logic          e_wr;
  logic [FW-1:0] e_wa;
  logic [DW-1:0] e_wd;
  logic [15:0]   e_wcnt;

  modport master (
    output h_wr, h_rd, h_a, h_wd, e_rd, e_ra, e_wr, e_wa, e_wd,
    input  h_gnt, h_rv, h_rdata, e_gnt, e_rv, e_rdata, e_wcnt
  );

  modport slave (
    input  h_wr, h_rd, h_a, h_wd, e_rd, e_ra, e_wr, e_wa, e_wd,
    output h_gnt, h_rv, h_rdata, e_gnt, e_rv, e_rdata, e_wcnt
  );
endinterface

// File: rtl/tdnn_bank_buf.sv
// rtl/tdnn_bank_buf.sv - banked buffer shared by host and engine; TDNN_BUF_FWD_EN forwards commit data to engine reads
module tdnn_bank_buf #(
  parameter int DW = 32,
  parameter int AW = 12,
  parameter int NB = 2
) (
  input logic          clk,
  input logic          rst_n,
  tdnn_bank_buf_if.slave bus
);
  localparam int BW    = $clog2(NB);
  localparam int FW    = AW + BW;
  localparam int DEPTH = 1 << AW;

  // commit stage: engine write waiting one cycle for its array slot
  logic          c_vld;
  logic [FW-1:0] c_a;
  logic [DW-1:0] c_d;

  logic [DW-1:0] mem [NB][DEPTH];

  logic [BW-1:0] h_bank, e_bank, c_bank;
  logic          h_gnt, e_gnt, e_fwd, e_blk, h_rd_go;

  assign h_bank = bus.h_a[FW-1 -: BW];
  assign e_bank = bus.e_ra[FW-1 -: BW];
  assign c_bank = c_a[FW-1 -: BW];

  // per-bank fixed priority: commit, then host, then engine read
  always_comb begin
    h_gnt = 1'b0;
    e_gnt = 1'b0;
    e_fwd = 1'b0;
    e_blk = 1'b0;
    h_gnt = rst_n && (bus.h_wr || bus.h_rd) && !(c_vld && (c_bank == h_bank));
    e_blk = (c_vld && (c_bank == e_bank)) || (h_gnt && (h_bank == e_bank));
`ifdef TDNN_BUF_FWD_EN
    e_fwd = c_vld && (c_a == bus.e_ra);
`else
    e_fwd = 1'b0;
`endif
    e_gnt = rst_n && bus.e_rd && (e_fwd || !e_blk);
  end

  assign h_rd_go   = h_gnt && !bus.h_wr;
  assign bus.h_gnt = h_gnt;
  assign bus.e_gnt = e_gnt;

  // capture each engine write into the commit stage; reset drops a pending one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_a   <= '0;
      c_d   <= '0;
    end else begin
      c_vld <= bus.e_wr;
      if (bus.e_wr) begin
        c_a <= bus.e_wa;
        c_d <= bus.e_wd;
      end
    end
  end

  // array writes: commit and host never share a bank in the same cycle
  always_ff @(posedge clk) begin
    if (c_vld) mem[c_bank][c_a[AW-1:0]] <= c_d;
    if (h_gnt && bus.h_wr) mem[h_bank][bus.h_a[AW-1:0]] <= bus.h_wd;
  end

  // registered read returns; data holds until the next granted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.h_rv    <= 1'b0;
      bus.h_rdata <= '0;
      bus.e_rv    <= 1'b0;
      bus.e_rdata <= '0;
    end else begin
      bus.h_rv <= h_rd_go;
      bus.e_rv <= e_gnt;
      if (h_rd_go) bus.h_rdata <= mem[h_bank][bus.h_a[AW-1:0]];
      if (e_gnt)   bus.e_rdata <= e_fwd ? c_d : mem[e_bank][bus.e_ra[AW-1:0]];
    end
  end

  // count array commits; the commit stage is empty on the release edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     bus.e_wcnt <= 16'd0;
    else if (c_vld) bus.e_wcnt <= bus.e_wcnt + 16'd1;
  end
endmodule

// File: tb/tb_tdnn_bank_buf.sv
// tb/tb_tdnn_bank_buf.sv - self-checking bench for tdnn_bank_buf against a behavioural model
module tb_tdnn_bank_buf;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int NB    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef TDNN_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdnn_bank_buf_if #(.DW(DW), .AW(AW), .NB(NB)) bus ();

  tdnn_bank_buf #(.DW(DW), .AW(AW), .NB(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // model: memory by full address, one pending engine write, counters
  logic [DW-1:0] ref_mem [int];
  bit            p_v;
  int            p_a;
  logic [DW-1:0] p_d;
  int            m_wcnt;
  logic [DW-1:0] m_hrd, m_erd;
  bit            m_hrd_ok, m_erd_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit hw, input bit hr, input int ha, input logic [DW-1:0] hwd,
                       input bit er, input int ea, input bit ew, input int wa,
                       input logic [DW-1:0] ewd);
    bus.h_wr = hw;  bus.h_rd = hr;  bus.h_a = ha[AW:0];  bus.h_wd = hwd;
    bus.e_rd = er;  bus.e_ra = ea[AW:0];
    bus.e_wr = ew;  bus.e_wa = wa[AW:0];  bus.e_wd = ewd;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  // one clock: check grants mid-cycle, advance the model, check returns after the edge
  task automatic cycle(input string tag);
    int ha, ea, wa, hb, eb, cb;
    bit hw, hr, er, ew, hg, eg, fwd, taken, hrd;
    logic [DW-1:0] hwd, ewd;
    @(negedge clk);
    hw = bus.h_wr;  hr = bus.h_rd;  ha = int'(bus.h_a);  hwd = bus.h_wd;
    er = bus.e_rd;  ea = int'(bus.e_ra);
    ew = bus.e_wr;  wa = int'(bus.e_wa);  ewd = bus.e_wd;
    hb = ha / DEPTH;  eb = ea / DEPTH;  cb = p_a / DEPTH;
    hg    = (hw || hr) && !(p_v && cb == hb);
    fwd   = FWD && p_v && (p_a == ea);
    taken = (p_v && cb == eb) || (hg && hb == eb);
    eg    = er && (fwd || !taken);
    chk({tag, ".h_gnt"}, 32'(bus.h_gnt), 32'(hg));
    chk({tag, ".e_gnt"}, 32'(bus.e_gnt), 32'(eg));
    hrd = hg && !hw;
    if (hrd) begin
      m_hrd_ok = ref_mem.exists(ha);
      if (m_hrd_ok) m_hrd = ref_mem[ha];
    end
    if (eg) begin
      if (fwd) begin
        m_erd = p_d;  m_erd_ok = 1'b1;
      end else begin
        m_erd_ok = ref_mem.exists(ea);
        if (m_erd_ok) m_erd = ref_mem[ea];
      end
    end
    if (p_v) begin
      ref_mem[p_a] = p_d;
      m_wcnt = (m_wcnt + 1) % 65536;
    end
    if (hg && hw) ref_mem[ha] = hwd;
    p_v = ew;  p_a = wa;  p_d = ewd;
    @(posedge clk);
    #1;
    chk({tag, ".h_rv"}, 32'(bus.h_rv), 32'(hrd));
    chk({tag, ".e_rv"}, 32'(bus.e_rv), 32'(eg));
    chk({tag, ".e_wcnt"}, 32'(bus.e_wcnt), 32'(m_wcnt));
    if (m_hrd_ok) chk({tag, ".h_rdata"}, bus.h_rdata, m_hrd);
    if (m_erd_ok) chk({tag, ".e_rdata"}, bus.e_rdata, m_erd);
  endtask

  // asynchronous reset: assert away from the edge, check outputs at once
  task automatic apply_reset(input string tag);
    idle();
    rst_n = 1'b0;
    #1;
    p_v = 1'b0;  m_wcnt = 0;
    m_hrd = '0;  m_erd = '0;  m_hrd_ok = 1'b1;  m_erd_ok = 1'b1;
    chk({tag, ".h_gnt"},   32'(bus.h_gnt), 32'd0);
    chk({tag, ".e_gnt"},   32'(bus.e_gnt), 32'd0);
    chk({tag, ".h_rv"},    32'(bus.h_rv),  32'd0);
    chk({tag, ".e_rv"},    32'(bus.e_rv),  32'd0);
    chk({tag, ".h_rdata"}, bus.h_rdata,    32'd0);
    chk({tag, ".e_rdata"}, bus.e_rdata,    32'd0);
    chk({tag, ".e_wcnt"},  32'(bus.e_wcnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    apply_reset("rst");

    // host write then read of the same address
    drive(1, 0, 'h0005, 32'h11, 0, 0, 0, 0, '0);     cycle("r36.wr");
    drive(0, 1, 'h0005, '0, 0, 0, 0, 0, '0);         cycle("r36.rd");
    chk("r36.h_rdata", bus.h_rdata, 32'h11);

    // engine write blocks a host read to the same bank for one cycle
    drive(0, 0, 0, '0, 0, 0, 1, 'h1003, 32'hAA);      cycle("r37.t0");
    drive(0, 1, 'h1010, '0, 0, 0, 0, 0, '0);         cycle("r37.t1");
    chk("r37.wcnt", 32'(bus.e_wcnt), 32'd1);
    cycle("r37.t2");

    // host and engine reads on different banks in the same cycle
    drive(1, 0, 'h0040, 32'h1234, 0, 0, 0, 0, '0);   cycle("r38.w0");
    drive(1, 0, 'h1040, 32'h5678, 0, 0, 0, 0, '0);   cycle("r38.w1");
    drive(0, 1, 'h0040, '0, 1, 'h1040, 0, 0, '0);    cycle("r38.rd");
    chk("r38.h_rdata", bus.h_rdata, 32'h1234);
    chk("r38.e_rdata", bus.e_rdata, 32'h5678);

    // host write wins the bank over an engine read
    drive(1, 0, 'h0020, 32'hBEEF, 1, 'h0021, 0, 0, '0); cycle("r39");

    // engine read of the address being committed
    drive(0, 0, 0, '0, 0, 0, 1, 'h0007, 32'h55);      cycle("r40.t0");
    drive(0, 0, 0, '0, 1, 'h0007, 0, 0, '0);         cycle("r40.t1");
    idle();                                          cycle("r40.t2");

    // reset with the commit stage full drops the pending write
    drive(1, 0, 'h0030, 32'h77, 0, 0, 0, 0, '0);     cycle("r41.w");
    drive(0, 0, 0, '0, 0, 0, 1, 'h0030, 32'h99);      cycle("r41.ew");
    #1;
    apply_reset("r41.rst");
    drive(0, 1, 'h0030, '0, 0, 0, 0, 0, '0);         cycle("r41.rd");
    chk("r41.h_rdata", bus.h_rdata, 32'h77);

    // randomized traffic over a small preloaded address set
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < 8; l++) begin
        drive(1, 0, b * DEPTH + l, $urandom, 0, 0, 0, 0, '0);
        cycle("init");
      end
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, NB - 1)) * DEPTH + int'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, NB - 1)) * DEPTH + int'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0,
            int'($urandom_range(0, NB - 1)) * DEPTH + int'($urandom_range(0, 7)), $urandom);
      cycle("rnd");
    end
    idle();
    cycle("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
